// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word-wide memory.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned requests into errors.
module load_store_unit #(
    parameter int memory_width = 32,
    parameter int memory_depth = 1024,
    localparam int AW = $clog2(memory_depth)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [AW+1:0]           req_addr,
    input  logic [memory_width-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [memory_width-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic                    RE,
    output logic                    WE,
    output logic [AW-1:0]           A,
    output logic [memory_width-1:0] WD,
    input  logic                    stall,
    input  logic [memory_width-1:0] RD
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        RESP
    } state_t;

    state_t state;

    logic [1:0]              cap_size;
    logic                    cap_unsigned;
    logic [1:0]              cap_off;
    logic [memory_width-1:0] cap_wdata;

    logic                    in_byte;
    logic                    in_half;
    logic                    in_word;
    logic                    in_misaligned;
    logic [1:0]              in_off;

    // Request decode: access size, lane offset and alignment fault.
    always_comb begin
        in_byte       = (req_size == 2'b00);
        in_half       = (req_size == 2'b01);
        in_word       = req_size[1];
        in_misaligned = 1'b0;
        in_off        = 2'b00;
        unique case (1'b1)
            in_byte: in_off = req_addr[1:0];
            in_half: in_off = {req_addr[1], 1'b0};
            in_word: in_off = 2'b00;
            default: in_off = 2'b00;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        in_misaligned = (in_half && req_addr[0]) ||
                        (in_word && (req_addr[1:0] != 2'b00));
`endif
    end

    // Select the addressed lane from a read word and extend it.
    function automatic logic [memory_width-1:0] load_extend(
        input logic [memory_width-1:0] rd,
        input logic [1:0]              size,
        input logic [1:0]              off,
        input logic                    uns
    );
        logic [7:0]              b;
        logic [15:0]             h;
        logic [memory_width-1:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        r = rd;
        unique case (1'b1)
            (size == 2'b00): begin
                if (uns) r = {{(memory_width-8){1'b0}}, b};
                else     r = {{(memory_width-8){b[7]}}, b};
            end
            (size == 2'b01): begin
                if (uns) r = {{(memory_width-16){1'b0}}, h};
                else     r = {{(memory_width-16){h[15]}}, h};
            end
            size[1]: r = rd;
            default: r = rd;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or half of a read word with store data.
    function automatic logic [memory_width-1:0] store_merge(
        input logic [memory_width-1:0] rd,
        input logic [memory_width-1:0] wd,
        input logic [1:0]              size,
        input logic [1:0]              off
    );
        logic [memory_width-1:0] r;
        r = rd;
        if (size == 2'b00)
            r[{off, 3'b000} +: 8] = wd[7:0];
        else if (size == 2'b01)
            r[{off[1], 4'b0000} +: 16] = wd[15:0];
        else
            r = wd;
        return r;
    endfunction

    // Ready only while idle and out of reset.
    assign req_ready = (state == IDLE) && !reset;

    // Access sequencer with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            RE           <= 1'b0;
            WE           <= 1'b0;
            A            <= '0;
            WD           <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_off      <= 2'b00;
            cap_wdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_off      <= in_off;
                        cap_wdata    <= req_wdata;
                        A            <= req_addr[AW+1:2];
                        if (in_misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!req_we) begin
                            state <= READ;
                            RE    <= 1'b1;
                        end else if (in_word) begin
                            state <= WRITE;
                            WE    <= 1'b1;
                            WD    <= req_wdata;
                        end else begin
                            state <= RMW_READ;
                            RE    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (!stall) begin
                        state     <= RESP;
                        RE        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= load_extend(RD, cap_size,
                                                 cap_off, cap_unsigned);
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        state     <= RESP;
                        WE        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                RMW_READ: begin
                    if (!stall) begin
                        state <= RMW_WRITE;
                        RE    <= 1'b0;
                        WE    <= 1'b1;
                        WD    <= store_merge(RD, cap_wdata,
                                             cap_size, cap_off);
                    end
                end
                RMW_WRITE: begin
                    if (!stall) begin
                        state     <= RESP;
                        WE        <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    RE    <= 1'b0;
                    WE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
